// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues single-word reads to instruction memory,
// buffers returned words and presents them to the control FSM through IR/start.
//
// Ports:
//   clock, reset_n        single clock, asynchronous active-low reset
//   enable                fetching permitted while high
//   mem_req/mem_addr      read request and its address (held until mem_ack)
//   mem_ack/mem_rdata     read completion and data (valid in the ack cycle)
//   IR/start              current instruction and its valid flag
//   ir_consume            control FSM has taken IR (ignored while start=0)
//   pc_load/pc_value      jump: redirect fetch to pc_value and flush buffer
//   pc                    address of the next word to fetch
//
// Configuration macro: INSTR_FETCH_PREFETCH_EN
//   defined   -> 2-entry buffer (IR plus one prefetch word)
//   undefined -> 1-entry buffer (IR only)
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] IR,
    output logic              start,
    input  logic              ir_consume,
    input  logic              pc_load,
    input  logic [DATA_W-1:0] pc_value,
    output logic [DATA_W-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              start_q, start_d;
    logic              req_q, req_d;
    logic              discard_q, discard_d;
    logic              outstanding;
    logic              acked;
    logic              slot_free;
`ifdef INSTR_FETCH_PREFETCH_EN
    logic [DATA_W-1:0] pf_q, pf_d;
    logic              pf_vld_q, pf_vld_d;
`endif

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= DATA_W'(RESET_PC);
            addr_q    <= DATA_W'(RESET_PC);
            ir_q      <= '0;
            start_q   <= 1'b0;
            req_q     <= 1'b0;
            discard_q <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
            pf_q      <= '0;
            pf_vld_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            ir_q      <= ir_d;
            start_q   <= start_d;
            req_q     <= req_d;
            discard_q <= discard_d;
`ifdef INSTR_FETCH_PREFETCH_EN
            pf_q      <= pf_d;
            pf_vld_q  <= pf_vld_d;
`endif
        end
    end

    // Next-state, buffer and request logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        ir_d      = ir_q;
        start_d   = start_q;
        discard_d = discard_q;
`ifdef INSTR_FETCH_PREFETCH_EN
        pf_d      = pf_q;
        pf_vld_d  = pf_vld_q;
`endif
        outstanding = (state_q == FETCH) && !mem_ack;
        acked       = (state_q == FETCH) && mem_ack;

        if (pc_load) begin
            // Jump wins over consume and capture; an in-flight read is
            // remembered so its data can be dropped when it returns.
            pc_d      = pc_value;
            start_d   = 1'b0;
            discard_d = outstanding || (discard_q && !acked);
`ifdef INSTR_FETCH_PREFETCH_EN
            pf_vld_d  = 1'b0;
`endif
        end else begin
            if (acked && discard_q) begin
                discard_d = 1'b0;
            end
            // Consume first so a same-cycle capture lands behind it
            if (ir_consume && start_q) begin
`ifdef INSTR_FETCH_PREFETCH_EN
                if (pf_vld_q) begin
                    ir_d     = pf_q;
                    pf_vld_d = 1'b0;
                end else begin
                    start_d  = 1'b0;
                end
`else
                start_d = 1'b0;
`endif
            end
            if (acked && !discard_q) begin
                pc_d = pc_q + DATA_W'(1);
                if (!start_d) begin
                    ir_d    = mem_rdata;
                    start_d = 1'b1;
                end
`ifdef INSTR_FETCH_PREFETCH_EN
                else begin
                    pf_d     = mem_rdata;
                    pf_vld_d = 1'b1;
                end
`endif
            end
        end

`ifdef INSTR_FETCH_PREFETCH_EN
        slot_free = !pf_vld_d;
`else
        slot_free = !start_d;
`endif

        // A read in flight keeps FETCH; otherwise decide from buffer occupancy
        if (!outstanding) begin
            if (!slot_free) begin
                state_d = FULL;
            end else if (enable) begin
                state_d = FETCH;
            end else begin
                state_d = IDLE;
            end
        end

        // Latch the address only when a new request starts
        if ((state_d == FETCH) && !outstanding) begin
            addr_d = pc_d;
        end
        req_d = (state_d == FETCH);
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign IR       = ir_q;
    assign start    = start_q;
    assign pc       = pc_q;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: fetch address loaded on reset.
REQ-002 Parameter DATA_W, default 16: instruction and address width, fixed at 16.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  fetching permitted while high.
REQ-006 mem_req  output  1  instruction memory read request.
REQ-007 mem_addr  output  16  read address; equals pc while mem_req is high.
REQ-008 mem_ack  input  1  memory completes the read in this cycle.
REQ-009 mem_rdata  input  16  read data, valid only in the mem_ack cycle.
REQ-010 IR  output  16  current instruction presented to the control state machine.
REQ-011 start  output  1  IR holds a valid instruction.
REQ-012 ir_consume  input  1  control state machine has taken IR; ignored when start is low.
REQ-013 pc_load  input  1  jump request: redirect fetch to pc_value and flush.
REQ-014 pc_value  input  16  jump target.
REQ-015 pc  output  16  address of the next word to fetch.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH and FULL, registered, one-hot or binary.
REQ-017 IDLE -> FETCH when enable=1 and a buffer slot is free; IDLE -> FULL when all slots are occupied.
REQ-018 In FETCH, mem_req SHALL be 1 and mem_addr SHALL hold pc stable until the cycle mem_ack=1 is sampled.
REQ-019 On mem_ack in FETCH: write mem_rdata into the buffer and set pc = pc+1, wrapping 16'hFFFF -> 16'h0000. The next state SHALL be FETCH if enable=1 and a slot is still free, FULL if no slot is free, else IDLE.
REQ-020 When the buffer empties into IR, IR and start SHALL update on the same edge as the mem_ack capture. Latency from mem_req rising to start=1 is the memory ack delay plus 0 cycles.
REQ-021 When ir_consume=1 and start=1, IR SHALL advance to the next buffered word, or start SHALL drop to 0 if the buffer is empty. FULL -> FETCH when enable=1, otherwise FULL -> IDLE.
REQ-022 If ir_consume and mem_ack occur in the same cycle, the consume SHALL be applied first. No word is lost or duplicated, and order is preserved.
REQ-023 On pc_load, set pc = pc_value, clear all buffered words, and set start=0 on the next edge. pc_load has priority over ir_consume and over mem_ack capture.
REQ-024 If pc_load occurs while a request is outstanding, mem_req SHALL stay high until mem_ack. The returned word SHALL be discarded, then fetch SHALL resume from pc_value.
REQ-025 If enable falls during FETCH, the outstanding request SHALL complete and be captured, and no new request SHALL be issued.
REQ-026 mem_req SHALL never be asserted while the buffer is full.

Reset
REQ-027 When reset_n=0, asynchronously set state=IDLE, pc=RESET_PC, IR=16'h0000, start=0, mem_req=0, buffer empty, discard flag cleared.
REQ-028 Reset mid-request abandons the request. After reset_n rises, the memory SHALL NOT see mem_req until the first enabled clock edge.

Configuration
REQ-029 Macro INSTR_FETCH_PREFETCH_EN: when defined, the buffer SHALL be 2 entries (IR plus one prefetch word), so fetching continues while start=1.
REQ-030 When INSTR_FETCH_PREFETCH_EN is undefined, the buffer SHALL be 1 entry (IR only). A new fetch SHALL begin only after ir_consume empties IR.

Verification
REQ-031 Reset with RESET_PC=16'h0000, enable=1, memory acks with a 1-cycle delay returning 16'h0001 -> mem_addr=16'h0000, then IR=16'h0001, start=1, pc=16'h0001.
REQ-032 Sequential words 16'h0001..16'h0007 at addresses 0..6, with ir_consume pulsed each time start=1 -> IR takes values 1..7 in order with no gaps or repeats.
REQ-033 With PREFETCH_EN, hold ir_consume=0 -> exactly 2 reads complete, then FULL with mem_req=0. Without PREFETCH_EN -> exactly 1 read, then FULL.
REQ-034 pc_load=1 with pc_value=16'h0040 while a request to 16'h0003 is pending -> the word from 16'h0003 is discarded, the next mem_addr is 16'h0040, and start=0 until that word returns.
REQ-035 pc=16'hFFFF, fetch acked -> pc=16'h0000, and the next mem_addr is 16'h0000.
REQ-036 Assert reset_n=0 mid-FETCH -> mem_req=0, start=0 and pc=RESET_PC immediately, with no clock edge required.
